// File: rtl/apb_data_master_if.sv
// APB bus between the data-memory initiator and the word memory.
// Master drives the address/control/write-data side; slave returns prdata and valid.
// valid is the responder's completion strobe (pready equivalent).
interface apb_data_master_if;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        valid;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, valid
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, valid
    );
endinterface

// File: rtl/apb_data_master.sv
// APB initiator for MEM-stage 16-bit loads/stores onto a 32-bit word memory (stores are read-modify-write).
// Latency: load done 3 cycles after accept, store 5, plus one per wait state; done is a one-cycle pulse.
// Backpressure: busy stalls the pipeline until done; optional access timeout under APB_MASTER_TIMEOUT_EN.
module apb_data_master #(
    parameter logic [15:0] ADDR_HI = 16'h0000,
    parameter int          TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    apb_data_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, R_SETUP, R_ACCESS, W_SETUP, W_ACCESS, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:1] addr_q;
    logic [15:0] wdata_q;
    logic        store_q;
    logic [31:0] merged_q;
    logic [15:0] rdata_q;
    logic        req;
    logic        in_access;
    logic        timeout;
    logic        addr_unused;

    // Byte lane bit is meaningless on a halfword-only port.
    assign addr_unused = addr[0];
    assign req         = mem_read | mem_write;
    assign in_access   = (state == R_ACCESS) || (state == W_ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // This cycle would be the TIMEOUT-th access cycle without a completion.
    assign timeout = (wait_cnt == CW'(TIMEOUT - 1)) && !bus.valid;

    // Wait counter: cleared in each setup cycle so it restarts on ACCESS entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if ((state == R_SETUP) || (state == W_SETUP))
            wait_cnt <= '0;
        else if (in_access && !bus.valid)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Error flag is high exactly for the done pulse that a timeout produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= in_access && timeout;
    end

    assign err = err_q;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: read phase always first; stores follow with the write phase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req) state_nxt = R_SETUP;
            R_SETUP:  state_nxt = R_ACCESS;
            R_ACCESS: begin
                if (bus.valid)    state_nxt = store_q ? W_SETUP : DONE;
                else if (timeout) state_nxt = DONE;
            end
            W_SETUP:  state_nxt = W_ACCESS;
            W_ACCESS: if (bus.valid || timeout) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; psel falls with the async state reset.
    always_comb begin
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE:     busy = req;
            R_SETUP:  bus.psel = 1'b1;
            R_ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
            end
            W_SETUP:  begin
                bus.psel   = 1'b1;
                bus.pwrite = 1'b1;
            end
            W_ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                bus.pwrite  = 1'b1;
            end
            DONE:     begin
                busy = 1'b0;
                done = 1'b1;
            end
            default:  busy = 1'b0;
        endcase
        bus.paddr = bus.psel ? {ADDR_HI, addr_q[15:2], 2'b00} : 32'h0;
    end

    // Request latch on accept; halfword capture / merge on read completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            if ((state == IDLE) && req) begin
                addr_q  <= addr[15:1];
                wdata_q <= wdata;
                store_q <= mem_write;
            end
            if ((state == R_ACCESS) && bus.valid) begin
                // Upper halfword holds the lower address.
                if (store_q)
                    merged_q <= addr_q[1] ? {bus.prdata[31:16], wdata_q}
                                          : {wdata_q, bus.prdata[15:0]};
                else
                    rdata_q  <= addr_q[1] ? bus.prdata[15:0] : bus.prdata[31:16];
            end
        end
    end

    assign rdata      = rdata_q;
    assign bus.pwdata = merged_q;

endmodule
